// File: rtl/nes_video_pkg.sv
// nes_video_pkg: NES 2C02 palette ROM and VGA timing helpers shared by the scanout path.
package nes_video_pkg;
  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb_t;
  function automatic int tot(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction
  function automatic int centre(input int act, input int src, input int scale);
    return (act - src * scale) / 2;
  endfunction
  function automatic rgb_t rgb666(input logic [23:0] c);
    return {c[23:18], c[15:10], c[7:2]};
  endfunction
  localparam rgb_t PALETTE [64] = '{
    rgb666(24'h7C7C7C), rgb666(24'h0000FC), rgb666(24'h0000BC), rgb666(24'h4428BC),
    rgb666(24'h940084), rgb666(24'hA80020), rgb666(24'hA81000), rgb666(24'h881400),
    rgb666(24'h503000), rgb666(24'h007800), rgb666(24'h006800), rgb666(24'h005800),
    rgb666(24'h004058), rgb666(24'h000000), rgb666(24'h000000), rgb666(24'h000000),
    rgb666(24'hBCBCBC), rgb666(24'h0078F8), rgb666(24'h0058F8), rgb666(24'h6844FC),
    rgb666(24'hD800CC), rgb666(24'hE40058), rgb666(24'hF83800), rgb666(24'hE45C10),
    rgb666(24'hAC7C00), rgb666(24'h00B800), rgb666(24'h00A800), rgb666(24'h00A844),
    rgb666(24'h008888), rgb666(24'h000000), rgb666(24'h000000), rgb666(24'h000000),
    rgb666(24'hF8F8F8), rgb666(24'h3CBCFC), rgb666(24'h6888FC), rgb666(24'h9878F8),
    rgb666(24'hF878F8), rgb666(24'hF85898), rgb666(24'hF87858), rgb666(24'hFCA044),
    rgb666(24'hF8B800), rgb666(24'hB8F818), rgb666(24'h58D854), rgb666(24'h58F898),
    rgb666(24'h00E8D8), rgb666(24'h787878), rgb666(24'h000000), rgb666(24'h000000),
    rgb666(24'hFCFCFC), rgb666(24'hA4E4FC), rgb666(24'hB8B8F8), rgb666(24'hD8B8F8),
    rgb666(24'hF8B8F8), rgb666(24'hF8A4C0), rgb666(24'hF0D0B0), rgb666(24'hFCE0A8),
    rgb666(24'hF8D878), rgb666(24'hD8F878), rgb666(24'hB8F8B8), rgb666(24'hB8F8D8),
    rgb666(24'h00FCFC), rgb666(24'hF8D8F8), rgb666(24'h000000), rgb666(24'h000000)
  };
endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters with undelayed active-high sync, active-area and frame markers.
module vga_timing
  import nes_video_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int H_FP = 16,
  parameter int H_SYN = 96,
  parameter int H_BP = 48,
  parameter int V_ACT = 480,
  parameter int V_FP = 10,
  parameter int V_SYN = 2,
  parameter int V_BP = 33,
  parameter int HW = $clog2(tot(H_ACT, H_FP, H_SYN, H_BP)),
  parameter int VW = $clog2(tot(V_ACT, V_FP, V_SYN, V_BP))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          vblank,
  output logic          frame_start
);
  localparam int H_TOT = tot(H_ACT, H_FP, H_SYN, H_BP);
  localparam int V_TOT = tot(V_ACT, V_FP, V_SYN, V_BP);
  logic h_last, v_last;
  assign h_last = hcnt == HW'(H_TOT - 1);
  assign v_last = vcnt == VW'(V_TOT - 1);
  assign hs = hcnt >= HW'(H_ACT + H_FP) && hcnt < HW'(H_ACT + H_FP + H_SYN);
  assign vs = vcnt >= VW'(V_ACT + V_FP) && vcnt < VW'(V_ACT + V_FP + V_SYN);
  assign de = hcnt < HW'(H_ACT) && vcnt < VW'(V_ACT);
  assign vblank = vcnt >= VW'(V_ACT);
  always_ff @(posedge clk)
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hcnt <= h_last ? '0 : hcnt + 1'b1;
      if (h_last) vcnt <= v_last ? '0 : vcnt + 1'b1;
      frame_start <= h_last && v_last;
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: integer-scaled, centred NES framebuffer to VGA pins through the 2C02 palette.
// Define VGA_SCANOUT_SCANLINE_EN to halve in-window colour on odd sub-lines.
module vga_scanout
  import nes_video_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int H_FP = 16,
  parameter int H_SYN = 96,
  parameter int H_BP = 48,
  parameter int V_ACT = 480,
  parameter int V_FP = 10,
  parameter int V_SYN = 2,
  parameter int V_BP = 33,
  parameter int SRC_W = 256,
  parameter int SRC_H = 240,
  parameter int SCALE = 2,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter int RGB_W = 4,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [5:0]        border_idx,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [5:0]        vram_data,
  output logic [RGB_W-1:0]  vga_r,
  output logic [RGB_W-1:0]  vga_g,
  output logic [RGB_W-1:0]  vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vblank,
  output logic              frame_start
);
  localparam int V_TOT = tot(V_ACT, V_FP, V_SYN, V_BP);
  localparam int HW = $clog2(tot(H_ACT, H_FP, H_SYN, H_BP));
  localparam int VW = $clog2(V_TOT);
  localparam int H_OFS = centre(H_ACT, SRC_W, SCALE);
  localparam int V_OFS = centre(V_ACT, SRC_H, SCALE);
  localparam logic [1:0] SC_M1 = 2'(SCALE - 1);
  logic [HW-1:0] hcnt, hrel;
  logic [VW-1:0] vcnt, vrel;
  logic hs, vs, de, in_win, last_col, dim;
  logic [ADDR_W-1:0] row_base, src_x;
  logic [1:0] sub_x, sub_y;
  logic [RD_LAT:0] hs_d, vs_d, de_d, win_d;
  rgb_t pal;
  vga_timing #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst(rst), .ce(ce), .hcnt(hcnt), .vcnt(vcnt), .hs(hs), .vs(vs),
    .de(de), .vblank(vblank), .frame_start(frame_start)
  );
  // Offsets wrap to large values left/above the window, so one compare per axis suffices.
  assign hrel = hcnt - HW'(H_OFS);
  assign vrel = vcnt - VW'(V_OFS);
  assign in_win = de && hrel < HW'(SRC_W * SCALE) && vrel < VW'(SRC_H * SCALE);
  assign last_col = hrel == HW'(SRC_W * SCALE - 1);
  always_ff @(posedge clk)
    if (rst) begin
      vram_addr <= '0;
      row_base <= '0;
      src_x <= '0;
      sub_x <= '0;
      sub_y <= '0;
    end else if (ce) begin
      if (vcnt == VW'(V_TOT - 1)) begin
        row_base <= '0;
        src_x <= '0;
        sub_x <= '0;
        sub_y <= '0;
      end else if (in_win) begin
        vram_addr <= row_base + src_x;
        sub_x <= (last_col || sub_x == SC_M1) ? '0 : sub_x + 2'd1;
        src_x <= last_col ? '0 : sub_x == SC_M1 ? src_x + 1'b1 : src_x;
        if (last_col) begin
          sub_y <= sub_y == SC_M1 ? '0 : sub_y + 2'd1;
          row_base <= sub_y == SC_M1 ? row_base + ADDR_W'(SRC_W) : row_base;
        end
      end
    end
`ifdef VGA_SCANOUT_SCANLINE_EN
  logic [RD_LAT:0] odd_d;
  always_ff @(posedge clk)
    if (rst) odd_d <= '0;
    else if (ce) odd_d <= {odd_d[RD_LAT-1:0], sub_y[0]};
  assign dim = (SCALE > 1) && win_d[RD_LAT] && odd_d[RD_LAT];
`else
  assign dim = 1'b0;
`endif
  assign pal = PALETTE[win_d[RD_LAT] ? vram_data : border_idx];
  function automatic logic [RGB_W-1:0] chan(input logic [5:0] c, input logic on, input logic half);
    logic [RGB_W-1:0] q;
    q = c[5 -: RGB_W];
    return on ? (half ? q >> 1 : q) : '0;
  endfunction
  always_ff @(posedge clk)
    if (rst) begin
      hs_d <= '0;
      vs_d <= '0;
      de_d <= '0;
      win_d <= '0;
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (ce) begin
      hs_d <= {hs_d[RD_LAT-1:0], hs};
      vs_d <= {vs_d[RD_LAT-1:0], vs};
      de_d <= {de_d[RD_LAT-1:0], de};
      win_d <= {win_d[RD_LAT-1:0], in_win};
      vga_hs <= hs_d[RD_LAT] ~^ SYNC_POL;
      vga_vs <= vs_d[RD_LAT] ~^ SYNC_POL;
      vga_r <= chan(pal.r, de_d[RD_LAT], dim);
      vga_g <= chan(pal.g, de_d[RD_LAT], dim);
      vga_b <= chan(pal.b, de_d[RD_LAT], dim);
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks a default-geometry and a small SCALE=3/RD_LAT=2 scanout against a raster model.
module tb_vga_scanout;
  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int sw; int sh; int sc; int lat;
  } cfg_t;
  localparam cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 256, 240, 2, 1};
  localparam cfg_t CB = '{40, 4, 6, 6, 30, 2, 2, 3, 10, 8, 3, 2};
  localparam logic [23:0] PAL888 [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0;
  logic [5:0] border = 6'h0F;
  logic [5:0] mem [65536];
  logic [15:0] a_addr;
  logic [7:0] b_addr;
  logic [5:0] da, db1, db2;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic a_hs, a_vs, a_vb, a_fs, b_hs, b_vs, b_vb, b_fs;
  int total = 0, bad = 0, k = 0, ea_a = 0, ea_b = 0;
  always #5 clk = ~clk;
  vga_scanout dut_a (
    .clk(clk), .rst(rst), .ce(ce), .border_idx(border), .vram_addr(a_addr), .vram_data(da),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hs(a_hs), .vga_vs(a_vs), .vblank(a_vb),
    .frame_start(a_fs)
  );
  vga_scanout #(
    .H_ACT(40), .H_FP(4), .H_SYN(6), .H_BP(6), .V_ACT(30), .V_FP(2), .V_SYN(2), .V_BP(3),
    .SRC_W(10), .SRC_H(8), .SCALE(3), .ADDR_W(8), .RD_LAT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .border_idx(border), .vram_addr(b_addr), .vram_data(db2),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hs(b_hs), .vga_vs(b_vs), .vblank(b_vb),
    .frame_start(b_fs)
  );
  // Synchronous VRAM: one register stage per read-latency tick, advancing only on ce.
  always @(posedge clk)
    if (ce) begin
      da <= mem[a_addr];
      db1 <= mem[b_addr];
      db2 <= db1;
    end
  function automatic int ht(cfg_t c);
    return c.ha + c.hf + c.hsw + c.hb;
  endfunction
  function automatic int ft(cfg_t c);
    return ht(c) * (c.va + c.vf + c.vsw + c.vb);
  endfunction
  function automatic logic [11:0] pal(int i);
    logic [23:0] c;
    c = PAL888[i];
    return {c[23:20], c[15:12], c[7:4]};
  endfunction
  function automatic int win_addr(cfg_t c, int p);
    int h, v, ho, vo;
    h = p % ht(c);
    v = p / ht(c);
    ho = (c.ha - c.sw * c.sc) / 2;
    vo = (c.va - c.sh * c.sc) / 2;
    if (h < ho || h >= ho + c.sw * c.sc || v < vo || v >= vo + c.sh * c.sc) return -1;
    return ((v - vo) / c.sc) * c.sw + (h - ho) / c.sc;
  endfunction
  function automatic logic [13:0] exp_pins(cfg_t c, int kk, logic [5:0] bord);
    int p, h, v, a;
    logic hs, vs;
    logic [11:0] rgb;
    if (kk < c.lat + 2) return {2'b11, 12'h000};
    p = (kk - c.lat - 2) % ft(c);
    h = p % ht(c);
    v = p / ht(c);
    hs = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw);
    vs = !(v >= c.va + c.vf && v < c.va + c.vf + c.vsw);
    a = win_addr(c, p);
    rgb = (h >= c.ha || v >= c.va) ? 12'h000 : a < 0 ? pal(bord) : pal(mem[a]);
`ifdef VGA_SCANOUT_SCANLINE_EN
    if (a >= 0 && c.sc > 1 && ((v - (c.va - c.sh * c.sc) / 2) % c.sc) % 2 == 1)
      rgb = {1'b0, rgb[11:9], 1'b0, rgb[7:5], 1'b0, rgb[3:1]};
`endif
    return {hs, vs, rgb};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, ex);
    end
  endtask
  task automatic check_all();
    logic [13:0] e;
    e = exp_pins(CA, k, border);
    chk("a_hs", 32'(a_hs), 32'(e[13]));
    chk("a_vs", 32'(a_vs), 32'(e[12]));
    chk("a_rgb", 32'({a_r, a_g, a_b}), 32'(e[11:0]));
    chk("a_addr", 32'(a_addr), ea_a);
    chk("a_vblank", 32'(a_vb), 32'((k % ft(CA)) / ht(CA) >= CA.va));
    chk("a_frame_start", 32'(a_fs), 32'(k > 0 && k % ft(CA) == 0));
    e = exp_pins(CB, k, border);
    chk("b_hs", 32'(b_hs), 32'(e[13]));
    chk("b_vs", 32'(b_vs), 32'(e[12]));
    chk("b_rgb", 32'({b_r, b_g, b_b}), 32'(e[11:0]));
    chk("b_addr", 32'(b_addr), ea_b);
    chk("b_vblank", 32'(b_vb), 32'((k % ft(CB)) / ht(CB) >= CB.va));
    chk("b_frame_start", 32'(b_fs), 32'(k > 0 && k % ft(CB) == 0));
  endtask
  task automatic step(input logic c, input logic r);
    int wa, wb;
    ce = c;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0;
      ea_a = 0;
      ea_b = 0;
    end else if (c) begin
      wa = win_addr(CA, k % ft(CA));
      wb = win_addr(CB, k % ft(CB));
      if (wa >= 0) ea_a = wa;
      if (wb >= 0) ea_b = wb;
      k++;
    end
    check_all();
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 6'($urandom);
    border = 6'($urandom);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 4100; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 1700; i++) step(1'(i % 2 == 0), 1'b0);
    for (int i = 0; i < ft(CB) && (k % ft(CB)) / ht(CB) != 20; i++) step(1'b1, 1'b0);
    border = 6'($urandom);
    step(1'b1, 1'b1);
    for (int i = 0; i < ft(CB) + 300; i++) step(1'b1, 1'b0);
    border = 6'h0F;
    step(1'b1, 1'b1);
    for (int i = 0; i < 900; i++) step(1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
